// File: rtl/draw_datapath_pkg.sv
// draw_datapath_pkg: constants, field layouts and types shared by the drawing
// datapath and the instruction initiators. Values here must match the initiators.
package draw_datapath_pkg;

  localparam int unsigned SCREEN_WIDTH      = 160;
  localparam int unsigned SCREEN_HEIGHT     = 120;
  localparam int unsigned X_COORD_WIDTH     = 8;
  localparam int unsigned Y_COORD_WIDTH     = 7;
  localparam int unsigned COLOUR_WIDTH      = 3;
  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned RESULT_WIDTH      = 32;
  localparam int unsigned OPCODE_WIDTH      = 4;
  localparam int unsigned RESERVED_WIDTH    = 9;
  localparam int unsigned COUNT_WIDTH       = 16;
  localparam int unsigned STATUS_WIDTH      = 2;
  localparam int unsigned RES_ZERO_WIDTH    = RESULT_WIDTH - COUNT_WIDTH - STATUS_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_CLEAR = OPCODE_WIDTH'(2);

  localparam logic [X_COORD_WIDTH-1:0] X_LAST       = X_COORD_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [Y_COORD_WIDTH-1:0] Y_LAST       = Y_COORD_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [COUNT_WIDTH-1:0]   CLEAR_PIXELS = COUNT_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT);

  typedef enum logic [STATUS_WIDTH-1:0] {
    STATUS_OK         = 2'd0,
    STATUS_BAD_OPCODE = 2'd1,
    STATUS_CLIPPED    = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EXEC_DRAW  = 2'd1,
    ST_EXEC_CLEAR = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  // Instruction word as seen on the bus, MSB first.
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [RESERVED_WIDTH-1:0] reserved;
    logic                      plot;
    logic [COLOUR_WIDTH-1:0]   colour;
    logic [Y_COORD_WIDTH-1:0]  y;
    logic [X_COORD_WIDTH-1:0]  x;
  } instr_t;

  // Fields kept after acceptance (reserved bits are dropped).
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic                     plot;
    logic [COLOUR_WIDTH-1:0]  colour;
    logic [Y_COORD_WIDTH-1:0] y;
    logic [X_COORD_WIDTH-1:0] x;
  } cmd_t;

  typedef struct packed {
    logic [COUNT_WIDTH-1:0]    count;
    logic [RES_ZERO_WIDTH-1:0] zero;
    status_e                   status;
  } result_t;

  function automatic result_t make_result(input logic [COUNT_WIDTH-1:0] count,
                                          input status_e status);
    result_t r;
    r.count  = count;
    r.zero   = '0;
    r.status = status;
    return r;
  endfunction

endpackage

// File: rtl/draw_datapath_if.sv
// draw_datapath_if: instruction handshake (start/instruction/finished/result)
// plus the VGA adapter pixel-write port.
//   master: initiator/pixel-sink side, drives start and instruction
//   slave : datapath side, drives finished, result and the vga_* signals
interface draw_datapath_if;
  import draw_datapath_pkg::*;

  logic                         start;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         finished;
  logic [RESULT_WIDTH-1:0]      result;
  logic [X_COORD_WIDTH-1:0]     vga_x;
  logic [Y_COORD_WIDTH-1:0]     vga_y;
  logic [COLOUR_WIDTH-1:0]      vga_colour;
  logic                         vga_plot;

  modport master (
    output start, instruction,
    input  finished, result, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, instruction,
    output finished, result, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/draw_datapath_scan.sv
// draw_datapath_scan: raster counter for screen clear, x fastest.
//   i_clock, i_reset : clock, async active-high reset
//   i_clear          : synchronous return to (0,0)
//   i_en             : advance one pixel
//   o_x, o_y         : current pixel (registered)
//   o_last_c         : current pixel is the bottom-right corner (combinational)
module draw_datapath_scan
  import draw_datapath_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_en,
  output logic [X_COORD_WIDTH-1:0] o_x,
  output logic [Y_COORD_WIDTH-1:0] o_y,
  output logic                     o_last_c
);

  logic [X_COORD_WIDTH-1:0] r_x;
  logic [Y_COORD_WIDTH-1:0] r_y;

  // Counter with wrap at the last column / row.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_COORD_WIDTH'(1);
      end else begin
        r_x <= r_x + X_COORD_WIDTH'(1);
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_last_c = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/draw_datapath.sv
// draw_datapath: responder end of the drawing instruction handshake. Accepts one
// instruction per start/finished handshake, executes NOP/DRAW/CLEAR on the VGA
// pixel-write port and returns a status word. All outputs are registered.
//   clock, reset : clock, async active-high reset
//   bus (slave)  : start/instruction in; finished/result/vga_* out
// Optional build macro DRAW_DATAPATH_CLIP_EN: DRAW outside the screen is
// suppressed and reported as clipped.
module draw_datapath
  import draw_datapath_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  draw_datapath_if.slave bus
);

  state_e                   r_state,      w_state_nxt;
  cmd_t                     r_cmd,        w_cmd_nxt;
  logic                     r_finished,   w_finished_nxt;
  result_t                  r_result,     w_result_nxt;
  logic [X_COORD_WIDTH-1:0] r_vga_x,      w_vga_x_nxt;
  logic [Y_COORD_WIDTH-1:0] r_vga_y,      w_vga_y_nxt;
  logic [COLOUR_WIDTH-1:0]  r_vga_colour, w_vga_colour_nxt;
  logic                     r_vga_plot,   w_vga_plot_nxt;

  instr_t                   w_instr;
  logic                     w_in_bounds;
  logic [X_COORD_WIDTH-1:0] w_scan_x;
  logic [Y_COORD_WIDTH-1:0] w_scan_y;
  logic                     w_scan_last_c;
  logic                     w_unused_reserved;

  assign w_instr           = instr_t'(bus.instruction);
  assign w_unused_reserved = ^w_instr.reserved;

`ifdef DRAW_DATAPATH_CLIP_EN
  assign w_in_bounds = (32'(r_cmd.x) < SCREEN_WIDTH) && (32'(r_cmd.y) < SCREEN_HEIGHT);
`else
  assign w_in_bounds = 1'b1;
`endif

  // Raster counter parks at (0,0) while idle so every clear starts top-left.
  draw_datapath_scan u_scan (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (r_state == ST_IDLE),
    .i_en     (r_state == ST_EXEC_CLEAR),
    .o_x      (w_scan_x),
    .o_y      (w_scan_y),
    .o_last_c (w_scan_last_c)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_finished   <= 1'b1;
      r_result     <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd        <= w_cmd_nxt;
      r_finished   <= w_finished_nxt;
      r_result     <= w_result_nxt;
      r_vga_x      <= w_vga_x_nxt;
      r_vga_y      <= w_vga_y_nxt;
      r_vga_colour <= w_vga_colour_nxt;
      r_vga_plot   <= w_vga_plot_nxt;
    end
  end

  // Next-state and next-output logic; the write strobe defaults low so it is a
  // single-cycle pulse outside the clear scan.
  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_nxt        = r_cmd;
    w_finished_nxt   = r_finished;
    w_result_nxt     = r_result;
    w_vga_x_nxt      = r_vga_x;
    w_vga_y_nxt      = r_vga_y;
    w_vga_colour_nxt = r_vga_colour;
    w_vga_plot_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_cmd_nxt.opcode = w_instr.opcode;
          w_cmd_nxt.plot   = w_instr.plot;
          w_cmd_nxt.colour = w_instr.colour;
          w_cmd_nxt.y      = w_instr.y;
          w_cmd_nxt.x      = w_instr.x;
          w_finished_nxt   = 1'b0;
          w_state_nxt      = (w_instr.opcode == OPCODE_CLEAR) ? ST_EXEC_CLEAR : ST_EXEC_DRAW;
        end
      end

      ST_EXEC_DRAW: begin
        w_vga_x_nxt      = r_cmd.x;
        w_vga_y_nxt      = r_cmd.y;
        w_vga_colour_nxt = r_cmd.colour;
        case (r_cmd.opcode)
          OPCODE_NOP: begin
            w_result_nxt = make_result('0, STATUS_OK);
          end
          OPCODE_DRAW: begin
            if (w_in_bounds) begin
              w_vga_plot_nxt = r_cmd.plot;
              w_result_nxt   = make_result(COUNT_WIDTH'(r_cmd.plot), STATUS_OK);
            end else begin
              w_result_nxt   = make_result('0, STATUS_CLIPPED);
            end
          end
          default: begin
            w_result_nxt = make_result('0, STATUS_BAD_OPCODE);
          end
        endcase
        w_state_nxt = ST_DONE;
      end

      ST_EXEC_CLEAR: begin
        w_vga_x_nxt      = w_scan_x;
        w_vga_y_nxt      = w_scan_y;
        w_vga_colour_nxt = r_cmd.colour;
        w_vga_plot_nxt   = 1'b1;
        if (w_scan_last_c) begin
          w_result_nxt = make_result(CLEAR_PIXELS, STATUS_OK);
          w_state_nxt  = ST_DONE;
        end
      end

      ST_DONE: begin
        // A still-held start must drop before the next instruction is taken.
        if (!bus.start) begin
          w_finished_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.finished   = r_finished;
  assign bus.result     = r_result;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_draw_datapath.sv
// tb_draw_datapath: directed bench for draw_datapath with a pixel scoreboard.
// Expected pixels (position, colour, cycle) are queued when an instruction is
// accepted and popped by a monitor on every vga_plot strobe.
module tb_draw_datapath;
  import draw_datapath_pkg::*;

  localparam int unsigned TIMEOUT = 25000;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic [31:0] cyc;
  } pix_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  draw_datapath_if bus();

  draw_datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  pix_t        exp_q[$];
  pix_t        got_pix;
  pix_t        want_pix;
  int unsigned errors    = 0;
  int unsigned checks    = 0;
  int unsigned cycle_cnt = 0;
  int unsigned pix_seen  = 0;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Pixel monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.vga_plot === 1'b1) begin
      got_pix.x   = bus.vga_x;
      got_pix.y   = bus.vga_y;
      got_pix.c   = bus.vga_colour;
      got_pix.cyc = 32'(cycle_cnt);
      checks++;
      if (exp_q.size() == 0) begin
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pixel: observed x=%0d y=%0d c=%0d cyc=%0d, required no pulse",
                 got_pix.x, got_pix.y, got_pix.c, got_pix.cyc);
        end
      end else begin
        want_pix = exp_q.pop_front();
        pix_seen++;
        assert (got_pix === want_pix) else begin
          errors++;
          $error("FAIL pixel: observed x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                 got_pix.x, got_pix.y, got_pix.c, got_pix.cyc,
                 want_pix.x, want_pix.y, want_pix.c, want_pix.cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h required=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic plot,
                                     input logic [2:0] c, input logic [6:0] y,
                                     input logic [7:0] x);
    return {op, 9'd0, plot, c, y, x};
  endfunction

  task automatic push_clear(input logic [2:0] c, input int unsigned a);
    pix_t p;
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        p.x   = 8'(xx);
        p.y   = 7'(yy);
        p.c   = c;
        p.cyc = 32'(a + 1 + yy * 160 + xx);
        exp_q.push_back(p);
      end
    end
  endtask

  // One handshake: start held for `hold` sampling edges, then wait for finished.
  task automatic run(input string tag, input logic [31:0] instr, input int unsigned hold,
                     input int unsigned exp_lat, input logic [31:0] exp_result,
                     input bit exp_pix, input bit exp_clear);
    int unsigned a;
    int unsigned lat;
    bit          done;
    pix_t        p;
    @(negedge clock);
    bus.start       = 1'b1;
    bus.instruction = instr;
    @(posedge clock);
    #1;
    a = cycle_cnt;
    check({tag, "_finished_fall"}, 32'(bus.finished), 32'd0);
    bus.instruction = $urandom();
    if (exp_pix) begin
      p.x   = instr[7:0];
      p.y   = instr[14:8];
      p.c   = instr[17:15];
      p.cyc = 32'(a + 1);
      exp_q.push_back(p);
    end
    if (exp_clear) push_clear(instr[17:15], a);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < TIMEOUT) begin
      if (lat == hold - 1) bus.start = 1'b0;
      @(posedge clock);
      #1;
      lat++;
      if (bus.finished === 1'b1) done = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp_result);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int unsigned a;
    int unsigned n;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.instruction = '0;
    #1;
    check("reset_finished", 32'(bus.finished), 32'd1);
    check("reset_result",   bus.result,        32'd0);
    check("reset_plot",     32'(bus.vga_plot), 32'd0);
    check("reset_xy",       {16'd0, bus.vga_x, bus.vga_y, 1'b0}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    run("draw",       mk(4'd1, 1'b1, 3'b111, 7'd5,  8'd10),  2, 2, 32'h0001_0000, 1'b1, 1'b0);
    run("draw_noplot",mk(4'd1, 1'b0, 3'b101, 7'd9,  8'd20),  2, 2, 32'h0000_0000, 1'b0, 1'b0);
    run("nop",        mk(4'd0, 1'b1, 3'b011, 7'd1,  8'd2),   2, 2, 32'h0000_0000, 1'b0, 1'b0);
    run("bad_op",     mk(4'hF, 1'b1, 3'b001, 7'd7,  8'd7),   2, 2, 32'h0000_0001, 1'b0, 1'b0);
    run("draw_edge",  mk(4'd1, 1'b1, 3'b100, 7'd119, 8'd159), 2, 2, 32'h0001_0000, 1'b1, 1'b0);
    run("draw_held",  mk(4'd1, 1'b1, 3'b110, 7'd40, 8'd80),  6, 6, 32'h0001_0000, 1'b1, 1'b0);
`ifdef DRAW_DATAPATH_CLIP_EN
    run("draw_clip",  mk(4'd1, 1'b1, 3'b101, 7'd3,  8'd200), 2, 2, 32'h0000_0002, 1'b0, 1'b0);
`else
    run("draw_noclip",mk(4'd1, 1'b1, 3'b101, 7'd3,  8'd200), 2, 2, 32'h0001_0000, 1'b1, 1'b0);
`endif
    run("clear",      mk(4'd2, 1'b0, 3'b010, 7'd0,  8'd0),   2, 19201, 32'h4B00_0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a clear.
    pix_seen = 0;
    @(negedge clock);
    bus.start       = 1'b1;
    bus.instruction = mk(4'd2, 1'b1, 3'b101, 7'd0, 8'd0);
    @(posedge clock);
    #1;
    a = cycle_cnt;
    push_clear(3'b101, a);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (pix_seen < 500 && n < 2000) begin
      @(negedge clock);
      #2;
      n++;
    end
    check("rst_mid_pixels", 32'(pix_seen), 32'd500);
    reset = 1'b1;
    #1;
    check("rst_mid_finished", 32'(bus.finished), 32'd1);
    check("rst_mid_plot",     32'(bus.vga_plot), 32'd0);
    check("rst_mid_result",   bus.result,        32'd0);
    check("rst_mid_vga",      {13'd0, bus.vga_x, bus.vga_y, bus.vga_colour, 1'b0}, 32'd0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("rst_idle_finished", 32'(bus.finished), 32'd1);

    run("post_reset_draw", mk(4'd1, 1'b1, 3'b011, 7'd60, 8'd33), 2, 2, 32'h0001_0000, 1'b1, 1'b0);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_datapath.md
Name: draw_datapath

Overview:
- Responder end of the instruction handshake used by the drawing controllers.
- Accepts one instruction per start/finished handshake, decodes the opcode, drives the VGA adapter pixel-write port, and returns a status word.
- Sits between the controller arbiter (instruction source) and the VGA adapter (pixel sink).

Parameters:
SCREEN_WIDTH, 160, visible columns
SCREEN_HEIGHT, 120, visible rows
X_COORD_WIDTH, 8, x field width
Y_COORD_WIDTH, 7, y field width
COLOUR_WIDTH, 3, colour field width
INSTRUCTION_WIDTH, 32, instruction bus width
RESULT_WIDTH, 32, result bus width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  instruction valid from initiator
instruction  in  INSTRUCTION_WIDTH  fields, MSB to LSB: opcode[31:28], reserved[27:19], plot[18], colour[17:15], y[14:8], x[7:0]
finished  out  1  1 = idle or done; 0 = busy
result  out  RESULT_WIDTH  status of last instruction
vga_x  out  X_COORD_WIDTH  pixel x
vga_y  out  Y_COORD_WIDTH  pixel y
vga_colour  out  COLOUR_WIDTH  pixel colour
vga_plot  out  1  one-cycle write strobe per pixel

Behaviour:
- Reset (async, any state including mid-CLEAR): state IDLE, finished=1, result=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
- Opcodes:
  - OPCODE_NOP=0: no pixel written.
  - OPCODE_DRAW=1: one pixel at (x,y) with colour, written only if plot=1.
  - OPCODE_CLEAR=2: fill the full screen with colour; plot bit ignored.
  - Any other opcode: error status, no pixel written.
- Result encoding: result[1:0] status (0 OK, 1 bad opcode, 2 clipped); result[31:16] pixels written by this instruction; result[15:2] = 0.
- All outputs are registered.
- States:
  - IDLE:
    - finished=1.
    - On the edge that samples start=1: latch instruction, finished<=0, then go to EXEC_DRAW (NOP, DRAW, bad opcode) or EXEC_CLEAR.
    - finished must fall on this same edge. The initiator holds start for exactly 2 cycles and samples finished from the 3rd cycle.
  - EXEC_DRAW:
    - One cycle. vga_plot<=plot&&valid, coordinates and colour from the latched fields.
    - result updated; then go to DONE.
  - EXEC_CLEAR:
    - Raster scan, x fastest, one pixel per cycle with vga_plot=1.
    - Counters wrap x at SCREEN_WIDTH-1 and y at SCREEN_HEIGHT-1.
    - After pixel (159,119): count=19200, go to DONE.
  - DONE:
    - vga_plot<=0.
    - If start=0: finished<=1, go to IDLE. Otherwise hold until start=0. A held start is never re-accepted.
- Latency: DRAW gives vga_plot one cycle after acceptance and finished two cycles after acceptance, given start is already low. CLEAR gives finished 19201 cycles after acceptance.
- start is ignored in every state except IDLE. instruction is sampled only at acceptance.
- result holds its value until the next instruction completes.

Optional Feature:
- Macro: DRAW_DATAPATH_CLIP_EN.
- Defined: a DRAW with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT writes no pixel (vga_plot stays 0) and returns status 2 with count 0.
- Undefined: no bounds check; coordinates pass through unmodified and status is 0.

Decomposition:
- Shared constants header holds OPCODE_WIDTH, the OPCODE_* values, the field widths, INSTRUCTION_WIDTH, RESULT_WIDTH, the SCREEN_* values, and the status codes.
- These must match those used by the initiators.
- One natural sub-module: draw_datapath_scan, the x/y raster counter with wrap and last-pixel flag, used by EXEC_CLEAR.

Test Plan:
- Reset: assert reset mid-CLEAR at pixel 500 -> immediately finished=1, vga_plot=0, result=0, state IDLE.
- DRAW: opcode=1, plot=1, colour=3'b111, y=5, x=10, start high 2 cycles -> finished=0 on first edge; single vga_plot pulse with vga_x=10, vga_y=5, colour 7; finished=1 after start drops; result=0x0001_0000.
- DRAW with plot=0, and NOP -> no vga_plot pulse; result=0x0000_0000; finished returns high.
- Bad opcode 4'hF -> no pulse; result[1:0]=1.
- CLEAR with colour 3'b010 -> exactly 19200 vga_plot pulses in raster order, last at (159,119); result[31:16]=19200; finished high 19201 cycles after acceptance.
- With DRAW_DATAPATH_CLIP_EN: DRAW at x=200, y=3 -> no pulse, result[1:0]=2. Without the macro: one pulse with vga_x=200.
